// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender: sign/zero/upper-extends a 16-bit immediate field to DATA_WIDTH behind a valid/ready stage.
// Optional IMMX prefix support (wide immediates built from prefix bytes) is enabled by defining IMM_PREFIX_EN.
module imm_extend_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   instructionOp,
    input  logic [15:0]           immediate,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] extendedImmediate,
    output logic [OP_WIDTH-1:0]   out_op,
    output logic                  prefix_pending
);

    localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(8'b01010000);
    localparam logic [OP_WIDTH-1:0] OP_SUBI  = OP_WIDTH'(8'b10010000);
    localparam logic [OP_WIDTH-1:0] OP_CMPI  = OP_WIDTH'(8'b10110000);
    localparam logic [OP_WIDTH-1:0] OP_BCOND = OP_WIDTH'(8'b11000000);
    localparam logic [OP_WIDTH-1:0] OP_LSHI0 = OP_WIDTH'(8'b10000000);
    localparam logic [OP_WIDTH-1:0] OP_LSHI1 = OP_WIDTH'(8'b10000001);
    localparam logic [OP_WIDTH-1:0] OP_LUI   = OP_WIDTH'(8'b11110000);

    typedef enum logic [1:0] {
        CLS_ZEXT  = 2'd0,
        CLS_SEXT8 = 2'd1,
        CLS_SEXT4 = 2'd2,
        CLS_UPPER = 2'd3
    } ext_class_t;

    function automatic ext_class_t classify(input logic [OP_WIDTH-1:0] op);
        case (op)
            OP_ADDI, OP_SUBI, OP_CMPI, OP_BCOND: classify = CLS_SEXT8;
            OP_LSHI0, OP_LSHI1:                  classify = CLS_SEXT4;
            OP_LUI:                              classify = CLS_UPPER;
            default:                             classify = CLS_ZEXT;
        endcase
    endfunction

    ext_class_t            w_class;
    logic [DATA_WIDTH-1:0] w_ext_normal;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_accept;
    logic                  w_produce;
    logic                  w_unused_imm_hi;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_ext;
    logic [OP_WIDTH-1:0]   r_out_op;

    assign w_unused_imm_hi = ^immediate[15:8];
    assign in_ready        = !r_out_valid || out_ready;
    assign w_accept        = in_valid && in_ready && !flush;

    // Plain extension of the immediate according to the opcode class
    always_comb begin
        w_class      = classify(instructionOp);
        w_ext_normal = '0;
        case (w_class)
            CLS_SEXT8: w_ext_normal = {{(DATA_WIDTH-8){immediate[7]}}, immediate[7:0]};
            CLS_SEXT4: w_ext_normal = {{(DATA_WIDTH-4){immediate[3]}}, immediate[3:0]};
            CLS_UPPER: w_ext_normal = DATA_WIDTH'({immediate[7:0], 8'h00});
            default:   w_ext_normal = DATA_WIDTH'(immediate[7:0]);
        endcase
    end

`ifdef IMM_PREFIX_EN
    localparam int                  PW      = DATA_WIDTH - 8;
    localparam logic [OP_WIDTH-1:0] OP_IMMX = OP_WIDTH'(8'b11110001);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_PREFIXED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_prefix;
    logic [PW-1:0]   w_prefix_next;
    logic [PW-1:0]   w_prefix_shift;
    logic            w_is_immx;

    assign w_is_immx      = (instructionOp == OP_IMMX);
    assign w_produce      = w_accept && !w_is_immx;
    assign prefix_pending = (r_state == ST_PREFIXED);

    // Older prefix bytes fall off the top; no overflow indication
    generate
        if (PW == 8) begin : g_prefix_byte
            assign w_prefix_shift = immediate[7:0];
        end else begin : g_prefix_wide
            assign w_prefix_shift = {r_prefix[PW-9:0], immediate[7:0]};
        end
    endgenerate

    // Prefix FSM state and prefix byte register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_prefix <= '0;
        end else begin
            r_state  <= w_state_next;
            r_prefix <= w_prefix_next;
        end
    end

    // Prefix FSM next state and next prefix value
    always_comb begin
        w_state_next  = r_state;
        w_prefix_next = r_prefix;
        if (flush) begin
            w_state_next  = ST_IDLE;
            w_prefix_next = '0;
        end else if (w_accept && w_is_immx) begin
            w_state_next  = ST_PREFIXED;
            w_prefix_next = w_prefix_shift;
        end else if (w_accept) begin
            w_state_next  = ST_IDLE;
            w_prefix_next = '0;
        end else begin
            w_state_next  = r_state;
            w_prefix_next = r_prefix;
        end
    end

    // Prefixed SEXT8/ZEXT ops concatenate the prefix verbatim; SEXT4/UPPER ignore it
    always_comb begin
        w_result = w_ext_normal;
        if ((r_state == ST_PREFIXED) && ((w_class == CLS_SEXT8) || (w_class == CLS_ZEXT))) begin
            w_result = {r_prefix, immediate[7:0]};
        end else begin
            w_result = w_ext_normal;
        end
    end
`else
    assign w_produce      = w_accept;
    assign w_result       = w_ext_normal;
    assign prefix_pending = 1'b0;
`endif

    // Output stage: load on accept, drain on consume, hold under backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_ext       <= '0;
            r_out_op    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_produce) begin
            r_out_valid <= 1'b1;
            r_ext       <= w_result;
            r_out_op    <= instructionOp;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid         = r_out_valid;
    assign extendedImmediate = r_ext;
    assign out_op            = r_out_op;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed steps, scoreboard queue fed on accept and drained on output handshake.
module tb_imm_extend_unit;

    localparam logic [7:0] ADDI  = 8'h50;
    localparam logic [7:0] SUBI  = 8'h90;
    localparam logic [7:0] CMPI  = 8'hB0;
    localparam logic [7:0] BCOND = 8'hC0;
    localparam logic [7:0] LSHI0 = 8'h80;
    localparam logic [7:0] LSHI1 = 8'h81;
    localparam logic [7:0] LUI   = 8'hF0;
    localparam logic [7:0] IMMX  = 8'hF1;
    localparam logic [7:0] ANDI  = 8'h10;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  instructionOp;
    logic [15:0] immediate;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] extendedImmediate;
    logic [7:0]  out_op;
    logic        prefix_pending;

    logic        d_valid, d_ready_in, d_out_valid, d_pending;
    logic        d_flush, d_out_ready;
    logic [7:0]  d_op, d_out_op;
    logic [15:0] d_imm;
    logic [31:0] d_ext;

    typedef struct packed {
        logic [7:0]  op;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    logic       m_pref;
    logic [7:0] m_p;
    int n_err = 0;
    int n_chk = 0;

    imm_extend_unit #(.DATA_WIDTH(16), .OP_WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instructionOp(instructionOp), .immediate(immediate), .out_valid(out_valid),
        .out_ready(out_ready), .extendedImmediate(extendedImmediate), .out_op(out_op),
        .prefix_pending(prefix_pending)
    );

    imm_extend_unit #(.DATA_WIDTH(32), .OP_WIDTH(8)) u_dut32 (
        .clk(clk), .reset(reset), .flush(d_flush), .in_valid(d_valid), .in_ready(d_ready_in),
        .instructionOp(d_op), .immediate(d_imm), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .extendedImmediate(d_ext), .out_op(d_out_op),
        .prefix_pending(d_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_ext(input logic [7:0] op, input logic [15:0] imm,
                                              input logic pref, input logic [7:0] p);
        logic [63:0] r;
        case (op)
            ADDI, SUBI, CMPI, BCOND: r = pref ? {48'h0, p, imm[7:0]} : {{56{imm[7]}}, imm[7:0]};
            LSHI0, LSHI1:            r = {{60{imm[3]}}, imm[3:0]};
            LUI:                     r = {48'h0, imm[7:0], 8'h00};
            default:                 r = pref ? {48'h0, p, imm[7:0]} : {56'h0, imm[7:0]};
        endcase
        return r & 64'h0000_0000_0000_FFFF;
    endfunction

    // Scoreboard: check the output stage against the queue, then retire/enqueue per handshake
    always @(negedge clk) begin
        logic acc;
        if (reset) begin
            q.delete();
            m_pref <= 1'b0;
            m_p    <= 8'h00;
        end else begin
            acc = in_valid && ((q.size() == 0) || out_ready);
            chk("out_valid", {63'h0, out_valid}, {63'h0, q.size() != 0});
            chk("in_ready", {63'h0, in_ready}, {63'h0, (q.size() == 0) || out_ready});
            chk("prefix_pending", {63'h0, prefix_pending}, {63'h0, m_pref});
            if (q.size() != 0) begin
                chk("sb_data", {48'h0, extendedImmediate}, q[0].data);
                chk("sb_op", {56'h0, out_op}, {56'h0, q[0].op});
            end
            if (flush) begin
                q.delete();
                m_pref <= 1'b0;
                m_p    <= 8'h00;
            end else begin
                if ((q.size() != 0) && out_ready) void'(q.pop_front());
                if (acc) begin
`ifdef IMM_PREFIX_EN
                    if (instructionOp == IMMX) begin
                        m_pref <= 1'b1;
                        m_p    <= immediate[7:0];
                    end else begin
                        q.push_back('{op: instructionOp, data: model_ext(instructionOp, immediate, m_pref, m_p)});
                        m_pref <= 1'b0;
                        m_p    <= 8'h00;
                    end
`else
                    q.push_back('{op: instructionOp, data: model_ext(instructionOp, immediate, 1'b0, 8'h00)});
`endif
                end
            end
        end
    end

    task automatic send(input logic [7:0] op, input logic [15:0] imm);
        int n;
        n = 0;
        instructionOp = op;
        immediate     = imm;
        in_valid      = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] val);
        in_valid = 1'b0;
        @(negedge clk);
        chk(tag, {48'h0, extendedImmediate}, {48'h0, val});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instructionOp = 8'h00; immediate = 16'h0;
        out_ready = 1'b1; d_valid = 1'b0; d_op = 8'h00; d_imm = 16'h0; d_flush = 1'b0; d_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_ext", {48'h0, extendedImmediate}, 64'h0);
        chk("rst_op", {56'h0, out_op}, 64'h0);
        chk("rst_pending", {63'h0, prefix_pending}, 64'h0);
        chk("rst_ext32", {32'h0, d_ext}, 64'h0);
        reset = 1'b0;

        send(ADDI, 16'h00F0);  expect_out("addi_sext8", 16'hFFF0);
        send(ANDI, 16'h00F0);  expect_out("andi_zext", 16'h00F0);
        send(LSHI1, 16'h000C); expect_out("lshi1_sext4", 16'hFFFC);
        send(LUI, 16'h0012);   expect_out("lui_upper", 16'h1200);

        // back-to-back burst at full rate
        send(SUBI, 16'h0080); send(LSHI0, 16'h0008); send(BCOND, 16'h007F);
        send(8'h33, 16'hABCD); send(LUI, 16'hFF81); send(CMPI, 16'h007F);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // backpressure
        out_ready = 1'b0;
        send(CMPI, 16'h0001);
        instructionOp = ADDI;
        immediate     = 16'h0002;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", {48'h0, extendedImmediate}, 64'h0001);
            chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #1;
        expect_out("bp_next", 16'h0002);

        // flush drops the held output and the op offered in the same cycle
        send(ADDI, 16'h0003);
        instructionOp = ANDI;
        immediate     = 16'h0044;
        flush         = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", {63'h0, out_valid}, 64'h0);
        @(posedge clk);
        #1;

`ifdef IMM_PREFIX_EN
        send(IMMX, 16'h00AB); send(ADDI, 16'h00CD); expect_out("prefix_abcd", 16'hABCD);
        send(IMMX, 16'h0012);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("prefix_flushed", {63'h0, prefix_pending}, 64'h0);
        @(posedge clk);
        #1;
        send(ADDI, 16'h00FF); expect_out("after_flush_addi", 16'hFFFF);
        send(IMMX, 16'h0034); send(LUI, 16'h0056); expect_out("prefix_lui", 16'h5600);
        send(IMMX, 16'h0011); send(IMMX, 16'h0022); send(8'h33, 16'h0033); expect_out("prefix_wrap", 16'h2233);
`else
        send(IMMX, 16'h0034); expect_out("immx_zext", 16'h0034);
        chk("immx_op", {56'h0, out_op}, {56'h0, IMMX});
`endif

        // 32-bit instance
        d_op = ADDI; d_imm = 16'h0080; d_valid = 1'b1;
        @(posedge clk);
        #1;
        d_op = LUI; d_imm = 16'h0012;
        @(negedge clk);
        chk("dw32_valid", {63'h0, d_out_valid}, 64'h1);
        chk("dw32_addi", {32'h0, d_ext}, 64'hFFFF_FF80);
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        @(negedge clk);
        chk("dw32_lui", {32'h0, d_ext}, 64'h0000_1200);
        @(posedge clk);
        #1;

        // async reset with a held output
        out_ready = 1'b0;
        send(ADDI, 16'h0005);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", {63'h0, out_valid}, 64'h0);
        chk("arst_ext", {48'h0, extendedImmediate}, 64'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
`ifdef IMM_PREFIX_EN
        send(IMMX, 16'h0077);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pending", {63'h0, prefix_pending}, 64'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
`endif
        send(ADDI, 16'h0090); expect_out("post_reset_addi", 16'hFF90);
        chk("post_reset_op", {56'h0, out_op}, {56'h0, ADDI});

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
